// File: rtl/countdown_timer_ctrl.sv
// MM:SS countdown sequencer: SET/RUN/PAUSE/DONE control, BCD count-down, blink-driven blanking.
// Optional: define AUTO_RELOAD_EN to reload the preset at zero and pulse done instead of entering DONE.
module countdown_timer_ctrl #(
    parameter int CLK_HZ   = 50000000,
    parameter int TICK_HZ  = 1,
    parameter int BLINK_HZ = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic        btn_sel,
    input  logic        btn_inc,
    output logic [15:0] value_bcd,
    output logic [3:0]  blank,
    output logic        done,
    output logic        running
);
    localparam int TICK_DIV   = CLK_HZ / TICK_HZ;
    localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    localparam logic [1:0] S_SET   = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state, state_n;
    logic [15:0]   preset, preset_n;
    logic [15:0]   count, count_n;
    logic [1:0]    cursor, cursor_n;
    logic [TW-1:0] tick_cnt, tick_n;
    logic [BW-1:0] blink_cnt, blink_cnt_n;
    logic          blink_ph, blink_ph_n;
    logic          reload_n;
    logic [3:0]    blank_n;

    function automatic logic [3:0] inc_dig(input logic [3:0] d, input logic [3:0] maxv);
        return (d >= maxv) ? 4'd0 : d + 4'd1;
    endfunction

    // BCD decrement with borrow; caller guarantees c != 0
    function automatic logic [15:0] bcd_dec(input logic [15:0] c);
        logic [15:0] r;
        r = c;
        if (c[3:0] != 4'd0) r[3:0] = c[3:0] - 4'd1;
        else begin
            r[3:0] = 4'd9;
            if (c[7:4] != 4'd0) r[7:4] = c[7:4] - 4'd1;
            else begin
                r[7:4] = 4'd5;
                if (c[11:8] != 4'd0) r[11:8] = c[11:8] - 4'd1;
                else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = c[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    logic        tick;
    logic [15:0] dec;
    assign tick = (tick_cnt == TICK_LAST);
    assign dec  = bcd_dec(count);

    assign blink_cnt_n = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
    assign blink_ph_n  = blink_ph ^ (blink_cnt == BLINK_LAST);

    always_comb begin
        state_n  = state;
        preset_n = preset;
        count_n  = count;
        cursor_n = cursor;
        tick_n   = tick_cnt;
        reload_n = 1'b0;
        case (state)
            S_SET: begin
                if (btn_inc)
                    preset_n[{cursor, 2'b00} +: 4] =
                        inc_dig(preset[{cursor, 2'b00} +: 4], (cursor == 2'd1) ? 4'd5 : 4'd9);
                if (btn_sel) cursor_n = cursor + 2'd1;
                if (btn_start && !btn_clear && preset != 16'h0000) begin
                    count_n = preset;
                    tick_n  = '0;
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (btn_clear) begin
                    state_n = S_SET;
                    count_n = preset;
                end else begin
                    tick_n = tick ? '0 : tick_cnt + 1'b1;
                    if (tick) begin
                        if (dec == 16'h0000) begin
`ifdef AUTO_RELOAD_EN
                            count_n  = preset;
                            reload_n = 1'b1;
`else
                            count_n = 16'h0000;
                            state_n = S_DONE;
`endif
                        end else
                            count_n = dec;
                    end
                    if (btn_start && state_n == S_RUN) state_n = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (btn_clear) begin
                    state_n = S_SET;
                    count_n = preset;
                end else if (btn_start)
                    state_n = S_RUN;
            end
            S_DONE: begin
                if (btn_clear || btn_start) begin
                    state_n = S_SET;
                    count_n = preset;
                end
            end
            default: state_n = S_SET;
        endcase
    end

    always_comb begin
        blank_n = 4'b0000;
        case (state_n)
            S_SET:   blank_n = {3'b000, blink_ph_n} << cursor_n;
            S_DONE:  blank_n = {4{blink_ph_n}};
            default: blank_n = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_SET;
            preset    <= '0;
            count     <= '0;
            cursor    <= '0;
            tick_cnt  <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
            value_bcd <= '0;
            blank     <= '0;
            done      <= 1'b0;
            running   <= 1'b0;
        end else begin
            state     <= state_n;
            preset    <= preset_n;
            count     <= count_n;
            cursor    <= cursor_n;
            tick_cnt  <= tick_n;
            blink_cnt <= blink_cnt_n;
            blink_ph  <= blink_ph_n;
            // outputs mirror the post-edge state so a pulse shows on the very next edge
            value_bcd <= (state_n == S_SET) ? preset_n : count_n;
            blank     <= blank_n;
            running   <= (state_n == S_RUN);
`ifdef AUTO_RELOAD_EN
            done      <= reload_n;
`else
            done      <= (state_n == S_DONE);
`endif
        end
    end
endmodule
